// File: rtl/switch_reader_if.sv
// -----------------------------------------------------------------------------
// switch_reader_if
// Bus bundle between the CPU/memorio side and the switch read peripheral.
//
// Signals:
//   swread    IOread strobe from CPU/memorio
//   sw        chip select for the switch port
//   swaddr    low 2 address bits (sub-address)
//   swin      raw, asynchronous board switches (24 bits)
//   swrdata   registered read data returned to the CPU
//   swchanged sticky "stable value updated" flag
//
// Modports:
//   master  CPU / board side: drives strobe, select, address and switches
//   slave   the peripheral: drives read data and the changed flag
// -----------------------------------------------------------------------------
interface switch_reader_if;
    logic        swread;
    logic        sw;
    logic [1:0]  swaddr;
    logic [23:0] swin;
    logic [15:0] swrdata;
    logic        swchanged;

    modport master (
        output swread,
        output sw,
        output swaddr,
        output swin,
        input  swrdata,
        input  swchanged
    );

    modport slave (
        input  swread,
        input  sw,
        input  swaddr,
        input  swin,
        output swrdata,
        output swchanged
    );
endinterface

// File: rtl/switch_reader.sv
// -----------------------------------------------------------------------------
// switch_reader
// CPU read side of the board I/O path. The 24 raw switches are passed through a
// two-flop synchroniser, then debounced with a single counter shared by all
// bits: the synchronised word must stay unchanged for DEBOUNCE_CYCLES cycles
// before it is copied into the stable register. Software reads the stable value
// through the same 2-bit sub-address scheme as the LED port and can poll a
// sticky flag that is set whenever the stable value changes.
//
// Sub-addresses (read when sw && swread at a clock edge):
//   00  stable[15:0]
//   10  {8'h00, stable[23:16]}
//   01  {15'b0, swchanged}, clears the flag (a same-edge set still wins)
//   11  16'h0000
//
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  switch_reader_if.slave (swread, sw, swaddr, swin in;
//        swrdata, swchanged out, both registered)
// -----------------------------------------------------------------------------
module switch_reader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    switch_reader_if.slave    bus
);

    // Terminal count: the counter saturates here and the candidate is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [23:0]      sync1_r;
    logic [23:0]      sync2_r;
    logic [23:0]      cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [23:0]      stable_r;
    logic [15:0]      swrdata_r;
    logic             swchanged_r;

    logic [23:0]      cand_s;
    logic [CNT_W-1:0] cnt_s;
    logic [23:0]      stable_s;
    logic             set_flag_s;
    logic             rd_en_s;
    logic             clr_flag_s;
    logic [15:0]      swrdata_s;
    logic             swchanged_s;

    // Two-flop synchroniser for the raw asynchronous switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 24'h000000;
            sync2_r <= 24'h000000;
        end else begin
            sync1_r <= bus.swin;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: any bit change restarts the shared count; once the
    // count saturates a differing candidate is promoted to the stable value.
    always_comb begin
        cand_s     = cand_r;
        cnt_s      = cnt_r;
        stable_s   = stable_r;
        set_flag_s = 1'b0;
        if (sync2_r != cand_r) begin
            cand_s = sync2_r;
            cnt_s  = {CNT_W{1'b0}};
        end else if (cnt_r < CNT_MAX) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            if (stable_r != cand_r) begin
                stable_s   = cand_r;
                set_flag_s = 1'b1;
            end else begin
                stable_s   = stable_r;
                set_flag_s = 1'b0;
            end
        end
    end

    // Read decode: select read data and detect a flag-clearing read.
    always_comb begin
        rd_en_s    = bus.sw && bus.swread;
        swrdata_s  = swrdata_r;
        clr_flag_s = 1'b0;
        if (rd_en_s) begin
            case (bus.swaddr)
                2'b00: swrdata_s = stable_r[15:0];
                2'b10: swrdata_s = {8'h00, stable_r[23:16]};
                2'b01: begin
                    // Returns the flag as it was before this edge.
                    swrdata_s  = {15'b0, swchanged_r};
                    clr_flag_s = 1'b1;
                end
                2'b11:   swrdata_s = 16'h0000;
                default: swrdata_s = 16'h0000;
            endcase
        end else begin
            swrdata_s = swrdata_r;
        end
    end

    // Sticky flag next-state: a set on the same edge as a clear wins so no
    // change event is lost.
    always_comb begin
        swchanged_s = swchanged_r;
        if (set_flag_s) begin
            swchanged_s = 1'b1;
        end else if (clr_flag_s) begin
            swchanged_s = 1'b0;
        end else begin
            swchanged_s = swchanged_r;
        end
    end

    // Debounce state, stable value and CPU-visible output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_r      <= 24'h000000;
            cnt_r       <= {CNT_W{1'b0}};
            stable_r    <= 24'h000000;
            swrdata_r   <= 16'h0000;
            swchanged_r <= 1'b0;
        end else begin
            cand_r      <= cand_s;
            cnt_r       <= cnt_s;
            stable_r    <= stable_s;
            swrdata_r   <= swrdata_s;
            swchanged_r <= swchanged_s;
        end
    end

    assign bus.swrdata   = swrdata_r;
    assign bus.swchanged = swchanged_r;

endmodule

// File: tb/tb_switch_reader.sv
// -----------------------------------------------------------------------------
// tb_switch_reader
// Directed bench for switch_reader with DEBOUNCE_CYCLES = 4. Each CPU read
// pushes its hand-computed expected data into a queue; a monitor process pops
// and compares on the negedge following every read edge. Flag and reset values
// are compared directly.
// -----------------------------------------------------------------------------
module tb_switch_reader;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic read_pend;
    logic [15:0] exp_q[$];

    switch_reader_if bus ();

    switch_reader #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether a read was presented at this edge.
    always @(posedge clk) begin
        read_pend <= bus.sw && bus.swread && !rst;
    end

    // Scoreboard monitor: compare read data the cycle after each read edge.
    always @(negedge clk) begin
        if (read_pend === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL rd_unexpected: got swrdata=%h, no expected value queued", bus.swrdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.swrdata !== e) begin
                    failures = failures + 1;
                    $display("FAIL rd_data: got swrdata=%h, expected %h at %0t", bus.swrdata, e, $time);
                end
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [15:0] exp);
        bus.sw     = 1'b1;
        bus.swread = 1'b1;
        bus.swaddr = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.sw     = 1'b0;
        bus.swread = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flag(input string name, input logic exp);
        check_val(name, {15'b0, bus.swchanged}, {15'b0, exp});
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        read_pend  = 1'b0;
        rst        = 1'b1;
        bus.sw     = 1'b0;
        bus.swread = 1'b0;
        bus.swaddr = 2'b00;
        bus.swin   = 24'hA5C3F0;

        // Reset with switches already on.
        wait_edges(1);
        check_val("rst_rdata", bus.swrdata, 16'h0000);
        check_flag("rst_flag", 1'b0);
        rst = 1'b0;

        // Held value lands at the 7th edge after release.
        wait_edges(6);
        check_flag("lat_before", 1'b0);
        do_read(2'b00, 16'h0000);          // edge 7: still old stable
        check_flag("lat_edge7", 1'b1);
        do_read(2'b00, 16'hC3F0);
        do_read(2'b10, 16'h00A5);

        // Flag read, clear, re-read, ignored read, unused address.
        do_read(2'b01, 16'h0001);
        check_flag("flag_cleared", 1'b0);
        do_read(2'b01, 16'h0000);
        do_read(2'b10, 16'h00A5);
        bus.sw     = 1'b0;
        bus.swread = 1'b1;
        bus.swaddr = 2'b00;
        wait_edges(1);
        bus.swread = 1'b0;
        check_val("sw0_hold", bus.swrdata, 16'h00A5);
        do_read(2'b11, 16'h0000);

        // Bounce: bit0 toggles every 2 cycles, then settles high.
        for (int i = 0; i < 10; i++) begin
            bus.swin[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            wait_edges(2);
        end
        check_flag("bounce_noflag", 1'b0);
        bus.swin[0] = 1'b1;
        wait_edges(6);
        check_flag("bounce_before", 1'b0);
        do_read(2'b00, 16'hC3F0);
        check_flag("bounce_edge7", 1'b1);
        do_read(2'b00, 16'hC3F1);
        do_read(2'b01, 16'h0001);
        wait_edges(10);
        check_flag("bounce_once", 1'b0);

        // New base value with bit5 low.
        bus.swin = 24'h5A3C0F;
        wait_edges(6);
        do_read(2'b00, 16'hC3F1);
        check_flag("base_set", 1'b1);
        do_read(2'b00, 16'h3C0F);
        do_read(2'b10, 16'h005A);
        do_read(2'b01, 16'h0001);

        // Glitch of exactly 4 cycles is rejected.
        bus.swin[5] = 1'b1;
        wait_edges(4);
        bus.swin[5] = 1'b0;
        wait_edges(12);
        check_flag("glitch4_flag", 1'b0);
        do_read(2'b00, 16'h3C0F);

        // Pulse of 5 cycles is accepted.
        bus.swin[5] = 1'b1;
        wait_edges(5);
        bus.swin[5] = 1'b0;
        wait_edges(2);
        check_flag("pulse5_flag", 1'b1);
        do_read(2'b00, 16'h3C2F);
        wait_edges(10);
        do_read(2'b01, 16'h0001);
        do_read(2'b00, 16'h3C0F);

        // Collision: flag read on the same edge as a stable update.
        bus.swin = 24'h123456;
        wait_edges(6);
        do_read(2'b01, 16'h0000);
        check_flag("collide_set_wins", 1'b1);
        do_read(2'b00, 16'h3456);
        do_read(2'b10, 16'h0012);
        check_flag("read_keeps_flag", 1'b1);

        // Reset mid-debounce discards the count.
        bus.swin = 24'hFFFFFF;
        wait_edges(4);
        rst = 1'b1;
        wait_edges(1);
        check_val("midrst_rdata", bus.swrdata, 16'h0000);
        check_flag("midrst_flag", 1'b0);
        rst = 1'b0;
        wait_edges(6);
        check_flag("midrst_before", 1'b0);
        do_read(2'b00, 16'h0000);
        check_flag("midrst_edge7", 1'b1);
        do_read(2'b00, 16'hFFFF);
        do_read(2'b10, 16'h00FF);
        do_read(2'b11, 16'h0000);

        wait_edges(2);
        check_val("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
